// File: rtl/safe_lock_ctrl.sv
// safe_lock_ctrl: keypad PIN lock sequencer.
// Consumes one scanner key code per cycle and runs PIN entry, the unlock
// window, PIN reprogramming and the failed-attempt lockout. All outputs are
// flops, so nothing on key_code reaches an output combinationally.
module safe_lock_ctrl #(
  parameter int                    CODE_LEN       = 4,
  parameter int                    MAX_FAILS      = 3,
  parameter int                    UNLOCK_CYCLES  = 500,
  parameter int                    LOCKOUT_CYCLES = 1000,
  parameter logic [CODE_LEN*4-1:0] DEFAULT_CODE   = 16'h1234
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] key_code,
  output logic       unlock,
  output logic       lockout,
  output logic       prog_mode,
  output logic       err,
  output logic       prog_done,
  output logic [2:0] digit_cnt
);

  localparam int          EW           = CODE_LEN * 4;
  localparam logic [2:0]  CNT_FULL     = 3'(CODE_LEN);
  localparam logic [2:0]  FAIL_LIMIT   = 3'(MAX_FAILS);
  localparam logic [15:0] UNLOCK_LOAD  = 16'(UNLOCK_CYCLES - 1);
  localparam logic [15:0] LOCKOUT_LOAD = 16'(LOCKOUT_CYCLES - 1);

  localparam logic [3:0] KEY_ENTER = 4'd10;
  localparam logic [3:0] KEY_STAR  = 4'd11;

  typedef enum logic [2:0] {
    ST_ENTRY,
    ST_CHECK,
    ST_OPEN,
    ST_PROG,
    ST_LOCKOUT
  } state_t;

  state_t          state_q, state_d;
  logic [EW-1:0]   ebuf_q, ebuf_d;
  logic [2:0]      cnt_q, cnt_d;
  logic            ovf_q, ovf_d;
  logic [EW-1:0]   code_q, code_d;
  logic [2:0]      fail_q, fail_d;
  logic [15:0]     timer_q, timer_d;

  logic            unlock_q, unlock_d;
  logic            lockout_q, lockout_d;
  logic            prog_mode_q, prog_mode_d;
  logic            err_q, err_d;
  logic            prog_done_q, prog_done_d;

  // Key classification and the buffer contents a digit would produce.
  logic            is_digit, is_enter, is_star;
  logic [EW-1:0]   cap_ebuf;
  logic [2:0]      cap_cnt;
  logic            cap_ovf;
  logic            code_match;
  logic            buf_ready;
  logic [2:0]      fail_inc;
  logic            timer_zero;

  // Decode the scanner code; 12..15 (including idle 13) are not key events.
  always_comb begin
    is_digit = (key_code <= 4'd9);
    is_enter = (key_code == KEY_ENTER);
    is_star  = (key_code == KEY_STAR);
  end

  // Result of capturing the current digit: shift in while there is room,
  // otherwise drop it and remember the overflow so the attempt cannot match.
  always_comb begin
    cap_ebuf = ebuf_q;
    cap_cnt  = cnt_q;
    cap_ovf  = ovf_q;
    if (cnt_q < CNT_FULL) begin
      cap_ebuf = (ebuf_q << 4) | EW'(key_code);
      cap_cnt  = cnt_q + 3'd1;
    end else begin
      cap_ovf  = 1'b1;
    end
  end

  // Shared comparisons used by several states.
  always_comb begin
    buf_ready  = (cnt_q == CNT_FULL) && !ovf_q;
    code_match = buf_ready && (ebuf_q == code_q);
    fail_inc   = fail_q + 3'd1;
    timer_zero = (timer_q == 16'd0);
  end

  // Next-state, datapath and output decode.
  always_comb begin
    state_d = state_q;
    ebuf_d  = ebuf_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    code_d  = code_q;
    fail_d  = fail_q;
    timer_d = timer_q;
    err_d       = 1'b0;
    prog_done_d = 1'b0;

    case (state_q)
      ST_ENTRY: begin
        if (is_digit) begin
          ebuf_d = cap_ebuf;
          cnt_d  = cap_cnt;
          ovf_d  = cap_ovf;
        end else if (is_star) begin
          ebuf_d = '0;
          cnt_d  = 3'd0;
          ovf_d  = 1'b0;
        end else if (is_enter && (cnt_q != 3'd0)) begin
          state_d = ST_CHECK;
        end
      end

      ST_CHECK: begin
        // Single evaluation cycle; any key presented now is dropped.
        ebuf_d = '0;
        cnt_d  = 3'd0;
        ovf_d  = 1'b0;
        if (code_match) begin
          fail_d  = 3'd0;
          timer_d = UNLOCK_LOAD;
          state_d = ST_OPEN;
        end else begin
          err_d  = 1'b1;
          fail_d = fail_inc;
          if (fail_inc == FAIL_LIMIT) begin
            timer_d = LOCKOUT_LOAD;
            state_d = ST_LOCKOUT;
          end else begin
            state_d = ST_ENTRY;
          end
        end
      end

      ST_OPEN: begin
        // Expiry wins over a key arriving in the final cycle.
        if (timer_zero) begin
          state_d = ST_ENTRY;
        end else if (is_enter) begin
          state_d = ST_ENTRY;
        end else if (is_star) begin
          timer_d = UNLOCK_LOAD;
          state_d = ST_PROG;
        end else begin
          timer_d = timer_q - 16'd1;
        end
      end

      ST_PROG: begin
        // Every exit from PROG empties the buffer so partial digits never
        // leak into the next ENTRY attempt.
        if (timer_zero) begin
          ebuf_d  = '0;
          cnt_d   = 3'd0;
          ovf_d   = 1'b0;
          state_d = ST_ENTRY;
        end else if (is_digit) begin
          ebuf_d  = cap_ebuf;
          cnt_d   = cap_cnt;
          ovf_d   = cap_ovf;
          timer_d = UNLOCK_LOAD;
        end else if (is_enter) begin
          ebuf_d  = '0;
          cnt_d   = 3'd0;
          ovf_d   = 1'b0;
          timer_d = UNLOCK_LOAD;
          if (buf_ready) begin
            code_d      = ebuf_q;
            prog_done_d = 1'b1;
            state_d     = ST_ENTRY;
          end else begin
            // Back-to-back rejected enters would otherwise stretch err to
            // two cycles; the second rejection still clears the buffer.
            err_d = !err_q;
          end
        end else if (is_star) begin
          ebuf_d  = '0;
          cnt_d   = 3'd0;
          ovf_d   = 1'b0;
          state_d = ST_ENTRY;
        end else begin
          timer_d = timer_q - 16'd1;
        end
      end

      ST_LOCKOUT: begin
        if (timer_zero) begin
          fail_d  = 3'd0;
          state_d = ST_ENTRY;
        end else begin
          timer_d = timer_q - 16'd1;
        end
      end

      default: begin
        state_d = ST_ENTRY;
      end
    endcase

    // Level outputs follow the state being entered, so they are registered
    // in step with the state flop.
    unlock_d    = (state_d == ST_OPEN);
    lockout_d   = (state_d == ST_LOCKOUT);
    prog_mode_d = (state_d == ST_PROG);
  end

  // State, datapath and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_ENTRY;
      ebuf_q      <= '0;
      cnt_q       <= 3'd0;
      ovf_q       <= 1'b0;
      code_q      <= DEFAULT_CODE;
      fail_q      <= 3'd0;
      timer_q     <= 16'd0;
      unlock_q    <= 1'b0;
      lockout_q   <= 1'b0;
      prog_mode_q <= 1'b0;
      err_q       <= 1'b0;
      prog_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ebuf_q      <= ebuf_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      code_q      <= code_d;
      fail_q      <= fail_d;
      timer_q     <= timer_d;
      unlock_q    <= unlock_d;
      lockout_q   <= lockout_d;
      prog_mode_q <= prog_mode_d;
      err_q       <= err_d;
      prog_done_q <= prog_done_d;
    end
  end

  assign unlock    = unlock_q;
  assign lockout   = lockout_q;
  assign prog_mode = prog_mode_q;
  assign err       = err_q;
  assign prog_done = prog_done_q;
  assign digit_cnt = cnt_q;

endmodule

// File: tb/tb_safe_lock_ctrl.sv
// Directed bench for safe_lock_ctrl with short unlock/lockout windows.
module tb_safe_lock_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] key_code;
  logic       unlock, lockout, prog_mode, err, prog_done;
  logic [2:0] digit_cnt;

  int total = 0;
  int bad   = 0;
  logic err_prev  = 1'b0;
  logic done_prev = 1'b0;

  typedef struct {
    logic       r;
    logic [3:0] key;
    logic [7:0] exp;   // {unlock, lockout, prog_mode, err, prog_done, digit_cnt}
  } vec_t;

  vec_t vecs[$];

  safe_lock_ctrl #(
    .CODE_LEN(4),
    .MAX_FAILS(3),
    .UNLOCK_CYCLES(8),
    .LOCKOUT_CYCLES(16),
    .DEFAULT_CODE(16'h1234)
  ) dut (
    .clk(clk),
    .rst(rst),
    .key_code(key_code),
    .unlock(unlock),
    .lockout(lockout),
    .prog_mode(prog_mode),
    .err(err),
    .prog_done(prog_done),
    .digit_cnt(digit_cnt)
  );

  always #5 clk = ~clk;

  task automatic add(input logic r, input logic [3:0] k, input logic u, input logic l,
                     input logic p, input logic e, input logic d, input int c);
    vec_t v;
    v.r   = r;
    v.key = k;
    v.exp = {u, l, p, e, d, 3'(c)};
    vecs.push_back(v);
  endtask

  // Four digits of a PIN; expected count climbs 1..4, prog_mode as given.
  task automatic add_pin(input logic [15:0] pin, input logic p);
    for (int i = 0; i < 4; i++) begin
      add(1'b0, pin[15-4*i -: 4], 1'b0, 1'b0, p, 1'b0, 1'b0, i + 1);
    end
  endtask

  // Drive one cycle, sample 1 time unit after the edge, check pulse rules.
  task automatic step(input logic r, input logic [3:0] k);
    rst      = r;
    key_code = k;
    @(posedge clk);
    #1;
    total++;
    if ((err && prog_done) || (err && err_prev) || (prog_done && done_prev)) begin
      bad++;
      $display("FAIL pulse_rule got err=%b done=%b prev_err=%b prev_done=%b required exclusive single-cycle pulses",
               err, prog_done, err_prev, done_prev);
    end
    err_prev  = err;
    done_prev = prog_done;
  endtask

  task automatic chk(input string name, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d required=%0d", name, got, exp);
    end
  endtask

  task automatic press_pin(input logic [15:0] pin);
    for (int i = 0; i < 4; i++) step(1'b0, pin[15-4*i -: 4]);
    step(1'b0, 4'd10);
    step(1'b0, 4'd13);
  endtask

  initial begin
    logic [3:0] lk [5];
    logic [7:0] got;
    int n;
    lk = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd10};
    rst      = 1'b1;
    key_code = 4'd13;

    // Reset state and ignored codes
    add(1, 13, 0,0,0,0,0, 0);
    add(1, 13, 0,0,0,0,0, 0);
    add(0, 12, 0,0,0,0,0, 0);
    add(0, 14, 0,0,0,0,0, 0);
    add(0, 15, 0,0,0,0,0, 0);

    // Correct PIN: unlock two cycles after enter, high for 8 samples
    add_pin(16'h1234, 0);
    add(0, 10, 0,0,0,0,0, 4);
    add(0, 13, 1,0,0,0,0, 0);
    add(0, 5,  1,0,0,0,0, 0);
    repeat (6) add(0, 13, 1,0,0,0,0, 0);
    add(0, 13, 0,0,0,0,0, 0);

    // Three wrong attempts; key during CHECK dropped; third locks out
    add_pin(16'h1235, 0);
    add(0, 10, 0,0,0,0,0, 4);
    add(0, 7,  0,0,0,1,0, 0);
    add_pin(16'h1235, 0);
    add(0, 10, 0,0,0,0,0, 4);
    add(0, 13, 0,0,0,1,0, 0);
    add_pin(16'h1235, 0);
    add(0, 10, 0,0,0,0,0, 4);
    add(0, 13, 0,1,0,1,0, 0);
    for (int i = 0; i < 5; i++) add(0, lk[i], 0,1,0,0,0, 0);
    repeat (10) add(0, 13, 0,1,0,0,0, 0);
    add(0, 13, 0,0,0,0,0, 0);
    add(0, 10, 0,0,0,0,0, 0);
    add(0, 13, 0,0,0,0,0, 0);

    // Overflow rejects; star clears the buffer; enter relocks early
    add_pin(16'h1234, 0);
    add(0, 5,  0,0,0,0,0, 4);
    add(0, 10, 0,0,0,0,0, 4);
    add(0, 13, 0,0,0,1,0, 0);
    add(0, 1,  0,0,0,0,0, 1);
    add(0, 2,  0,0,0,0,0, 2);
    add(0, 11, 0,0,0,0,0, 0);
    add_pin(16'h1234, 0);
    add(0, 10, 0,0,0,0,0, 4);
    add(0, 13, 1,0,0,0,0, 0);
    add(0, 10, 0,0,0,0,0, 0);

    // Reprogram to 9876; old PIN rejected, new PIN opens
    add_pin(16'h1234, 0);
    add(0, 10, 0,0,0,0,0, 4);
    add(0, 13, 1,0,0,0,0, 0);
    add(0, 11, 0,0,1,0,0, 0);
    add_pin(16'h9876, 1);
    add(0, 10, 0,0,0,0,1, 0);
    add(0, 13, 0,0,0,0,0, 0);
    add_pin(16'h1234, 0);
    add(0, 10, 0,0,0,0,0, 4);
    add(0, 13, 0,0,0,1,0, 0);
    add_pin(16'h9876, 0);
    add(0, 10, 0,0,0,0,0, 4);
    add(0, 13, 1,0,0,0,0, 0);
    add(0, 10, 0,0,0,0,0, 0);

    // Short entry in PROG errors and stays; star aborts with code kept
    add_pin(16'h9876, 0);
    add(0, 10, 0,0,0,0,0, 4);
    add(0, 13, 1,0,0,0,0, 0);
    add(0, 11, 0,0,1,0,0, 0);
    add(0, 9,  0,0,1,0,0, 1);
    add(0, 8,  0,0,1,0,0, 2);
    add(0, 10, 0,0,1,1,0, 0);
    add(0, 11, 0,0,0,0,0, 0);
    add_pin(16'h9876, 0);
    add(0, 10, 0,0,0,0,0, 4);
    add(0, 13, 1,0,0,0,0, 0);
    add(0, 10, 0,0,0,0,0, 0);

    foreach (vecs[i]) begin
      step(vecs[i].r, vecs[i].key);
      got = {unlock, lockout, prog_mode, err, prog_done, digit_cnt};
      total++;
      if (got !== vecs[i].exp) begin
        bad++;
        $display("FAIL vec%0d key=%0d got u=%b l=%b p=%b e=%b d=%b cnt=%0d required u=%b l=%b p=%b e=%b d=%b cnt=%0d",
                 i, vecs[i].key, got[7], got[6], got[5], got[4], got[3], got[2:0],
                 vecs[i].exp[7], vecs[i].exp[6], vecs[i].exp[5], vecs[i].exp[4],
                 vecs[i].exp[3], vecs[i].exp[2:0]);
      end
    end

    // PROG idle timeout: prog_mode lasts 8 samples, code unchanged
    press_pin(16'h9876);
    chk("open_before_prog", int'(unlock), 1);
    step(1'b0, 4'd11);
    n = 0;
    while (prog_mode === 1'b1 && n < 20) begin
      n++;
      step(1'b0, 4'd13);
    end
    chk("prog_timeout_len", n, 8);
    chk("prog_timeout_unlock", int'(unlock), 0);

    // Code kept after timeout; unlock window measured with no keys
    press_pin(16'h9876);
    n = 0;
    while (unlock === 1'b1 && n < 20) begin
      n++;
      step(1'b0, 4'd13);
    end
    chk("unlock_len", n, 8);

    // Reset mid-OPEN drops unlock on the next edge and restores 1234
    press_pin(16'h9876);
    chk("open_before_rst", int'(unlock), 1);
    step(1'b1, 4'd13);
    chk("rst_unlock", int'(unlock), 0);
    chk("rst_outputs", int'({unlock, lockout, prog_mode, err, prog_done, digit_cnt}), 0);
    step(1'b0, 4'd13);
    press_pin(16'h1234);
    chk("default_after_rst", int'(unlock), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
